// File: rtl/color_select_ctrl_if.sv
// Colour-request handshake between the selection initiator (master) and game logic (slave).
// The initiator holds COLOR_SELECTED stable while COLOR_SEL_SIG is high; the responder answers with CHANGING_COLOR.
interface color_select_ctrl_if;
    logic [2:0] COLOR_SELECTED;
    logic       COLOR_SEL_SIG;
    logic       CHANGING_COLOR;
    logic [2:0] CURRENT_COLOR;

    modport master (
        output COLOR_SELECTED,
        output COLOR_SEL_SIG,
        input  CHANGING_COLOR,
        input  CURRENT_COLOR
    );

    modport slave (
        input  COLOR_SELECTED,
        input  COLOR_SEL_SIG,
        output CHANGING_COLOR,
        output CURRENT_COLOR
    );
endinterface

// File: rtl/color_select_ctrl.sv
// Debounced buttons drive a palette cursor; each accepted confirm issues one request, strobe one cycle after the press.
// One request outstanding at most: presses during REQ/BUSY are dropped, and the move counts one cycle after CHANGING_COLOR falls.
module color_select_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [15:0] ACK_TIMEOUT     = 16'd1000,
    parameter logic [7:0]  MOVE_LIMIT      = 8'd25
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        BTN_LEFT,
    input  logic        BTN_RIGHT,
    input  logic        BTN_CONFIRM,
    input  logic [3:0]  COLOR_NUM,
    input  logic        START_NEW_GAME,
    output logic [2:0]  CURSOR,
    output logic [7:0]  MOVE_COUNT,
    output logic        OUT_OF_MOVES,
    output logic        REQ_ERROR,
    color_select_ctrl_if.master sel
);

    typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

    // Button bit order everywhere: [0]=left, [1]=right, [2]=confirm.
    logic [2:0]       sync1_q, sync2_q, db_q, db_prev_q;
    logic [2:0][15:0] db_cnt_q;
    logic [2:0]       press;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            db_cnt_q  <= '0;
        end else begin
            sync1_q   <= {BTN_CONFIRM, BTN_RIGHT, BTN_LEFT};
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            for (int i = 0; i < 3; i++) begin
                // A bounce back to the accepted level restarts the stability count.
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
                    db_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign press = db_q & ~db_prev_q;

    state_t      state_q, state_d;
    logic [2:0]  cursor_q, cursor_d, sel_q, sel_d;
    logic        sig_q, sig_d, err_q, err_d, oom_q, oom_d;
    logic [7:0]  moves_q, moves_d;
    logic [15:0] tmo_q, tmo_d;
    logic [3:0]  n_eff;
    logic [2:0]  n_max;

    always_comb begin
        n_eff = COLOR_NUM;
        if (COLOR_NUM < 4'd2) begin
            n_eff = 4'd2;
        end else if (COLOR_NUM > 4'd8) begin
            n_eff = 4'd8;
        end
        // N=8 wraps the low bits to 0, so 0-1 gives 7 as required.
        n_max = n_eff[2:0] - 3'd1;
    end

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        sel_d    = sel_q;
        sig_d    = sig_q;
        err_d    = 1'b0;
        oom_d    = oom_q;
        moves_d  = moves_q;
        tmo_d    = tmo_q;

        if (START_NEW_GAME) begin
            state_d  = IDLE;
            sig_d    = 1'b0;
            moves_d  = '0;
            oom_d    = 1'b0;
            cursor_d = '0;
            tmo_d    = '0;
        end else begin
            if ({1'b0, cursor_q} >= n_eff) begin
                cursor_d = '0;
            end else if (press[0] && !press[1]) begin
                cursor_d = (cursor_q == 3'd0) ? n_max : cursor_q - 3'd1;
            end else if (press[1] && !press[0]) begin
                cursor_d = (cursor_q == n_max) ? 3'd0 : cursor_q + 3'd1;
            end

            case (state_q)
                IDLE: begin
                    if (press[2] && (cursor_q != sel.CURRENT_COLOR) && !oom_q && !sel.CHANGING_COLOR) begin
                        sel_d   = cursor_q;
                        sig_d   = 1'b1;
                        tmo_d   = '0;
                        state_d = REQ;
                    end
                end
                REQ: begin
                    tmo_d = tmo_q + 16'd1;
                    if (sel.CHANGING_COLOR) begin
                        sig_d   = 1'b0;
                        state_d = BUSY;
                    end else if (tmo_q == ACK_TIMEOUT - 16'd1) begin
                        sig_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                BUSY: begin
                    if (!sel.CHANGING_COLOR) begin
                        moves_d = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
                        oom_d   = (moves_d >= MOVE_LIMIT);
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            cursor_q <= '0;
            sel_q    <= '0;
            sig_q    <= 1'b0;
            err_q    <= 1'b0;
            oom_q    <= 1'b0;
            moves_q  <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            sel_q    <= sel_d;
            sig_q    <= sig_d;
            err_q    <= err_d;
            oom_q    <= oom_d;
            moves_q  <= moves_d;
            tmo_q    <= tmo_d;
        end
    end

    assign CURSOR             = cursor_q;
    assign MOVE_COUNT         = moves_q;
    assign OUT_OF_MOVES       = oom_q;
    assign REQ_ERROR          = err_q;
    assign sel.COLOR_SELECTED = sel_q;
    assign sel.COLOR_SEL_SIG  = sig_q;

endmodule

// File: tb/tb_color_select_ctrl.sv
// Directed bench for color_select_ctrl: a cycle model built from the button/cursor/request rules
// is compared every cycle, and literal expectations pin the key scenarios.
`timescale 1ns/1ps
module tb_color_select_ctrl;
    localparam logic [15:0] DEB = 16'd4;
    localparam logic [15:0] ACK = 16'd8;
    localparam logic [7:0]  LIM = 8'd2;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1;
    logic       btn_l = 1'b0, btn_r = 1'b0, btn_c = 1'b0, start = 1'b0;
    logic [3:0] color_num = 4'd6;
    logic [2:0] cur_color = 3'd0;
    logic       chg = 1'b0;
    logic [2:0] cursor;
    logic [7:0] move_count;
    logic       oom, req_err;

    color_select_ctrl_if sel_if();
    assign sel_if.CHANGING_COLOR = chg;
    assign sel_if.CURRENT_COLOR  = cur_color;

    color_select_ctrl #(.DEBOUNCE_CYCLES(DEB), .ACK_TIMEOUT(ACK), .MOVE_LIMIT(LIM)) dut (
        .CLOCK(clk), .RESET_N(rst_n),
        .BTN_LEFT(btn_l), .BTN_RIGHT(btn_r), .BTN_CONFIRM(btn_c),
        .COLOR_NUM(color_num), .START_NEW_GAME(start),
        .CURSOR(cursor), .MOVE_COUNT(move_count), .OUT_OF_MOVES(oom), .REQ_ERROR(req_err),
        .sel(sel_if)
    );

    int vectors = 0, miscompares = 0;

    // Model: a level is accepted once the synchronised input has held it for DEB consecutive edges.
    int          m_cursor, m_moves, m_sel, m_phase;   // phase 0 idle, 1 waiting ack, 2 waiting drop
    logic        m_sig, m_err;
    longint      m_cyc, m_t0;
    logic [2:0]  m_r1, m_r2, m_db, m_press;
    logic [31:0] m_hist [3];

    always @(posedge clk or negedge rst_n) begin : model
        int n, cur_old;
        logic [2:0] raw, syncv, db_new;
        logic [31:0] mask;
        if (!rst_n) begin
            m_cursor = 0; m_moves = 0; m_sel = 0; m_phase = 0;
            m_sig = 0; m_err = 0; m_cyc = 0; m_t0 = 0;
            m_r1 = '0; m_r2 = '0; m_db = '0; m_press = '0;
            for (int b = 0; b < 3; b++) m_hist[b] = '0;
        end else begin
            n = (color_num < 2) ? 2 : (color_num > 8) ? 8 : int'(color_num);
            cur_old = m_cursor;
            m_err = 0;
            if (start) begin
                m_cursor = 0; m_phase = 0; m_sig = 0; m_moves = 0;
            end else begin
                if (m_cursor >= n) m_cursor = 0;
                else if (m_press[0] && !m_press[1]) m_cursor = (m_cursor == 0) ? n - 1 : m_cursor - 1;
                else if (m_press[1] && !m_press[0]) m_cursor = (m_cursor == n - 1) ? 0 : m_cursor + 1;
                if (m_phase == 0) begin
                    if (m_press[2] && cur_old != int'(cur_color) && m_moves < int'(LIM) && !chg) begin
                        m_sel = cur_old; m_sig = 1; m_t0 = m_cyc; m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    if (chg) begin
                        m_sig = 0; m_phase = 2;
                    end else if (m_cyc - m_t0 == longint'(ACK)) begin
                        m_sig = 0; m_err = 1; m_phase = 0;
                    end
                end else if (!chg) begin
                    if (m_moves < 255) m_moves = m_moves + 1;
                    m_phase = 0;
                end
            end
            raw = {btn_c, btn_r, btn_l};
            syncv = m_r2; m_r2 = m_r1; m_r1 = raw;
            mask = (32'd1 << DEB) - 32'd1;
            db_new = m_db;
            for (int b = 0; b < 3; b++) begin
                m_hist[b] = {m_hist[b][30:0], syncv[b]};
                if ((m_hist[b] & mask) == 32'd0 || (m_hist[b] & mask) == mask) db_new[b] = syncv[b];
            end
            m_press = db_new & ~m_db;
            m_db = db_new;
            m_cyc = m_cyc + 1;
        end
    end

    always @(negedge clk) begin : compare
        vectors++;
        if (cursor !== 3'(m_cursor) || move_count !== 8'(m_moves) || oom !== (m_moves >= int'(LIM)) ||
            req_err !== m_err || sel_if.COLOR_SEL_SIG !== m_sig || sel_if.COLOR_SELECTED !== 3'(m_sel)) begin
            miscompares++;
            $display("FAIL cycle t=%0t dut: cur=%0d mv=%0d oom=%0b err=%0b sig=%0b sel=%0d model: cur=%0d mv=%0d oom=%0b err=%0b sig=%0b sel=%0d",
                     $time, cursor, move_count, oom, req_err, sel_if.COLOR_SEL_SIG, sel_if.COLOR_SELECTED,
                     m_cursor, m_moves, m_moves >= int'(LIM), m_err, m_sig, m_sel);
        end
    end

    int err_seen = 0, cursor_moves = 0;
    logic [2:0] last_cursor = 3'd0;
    always @(negedge clk) begin
        if (req_err === 1'b1) err_seen++;
        if (cursor !== last_cursor) cursor_moves++;
        last_cursor = cursor;
    end

    // Responder: acknowledges on the third cycle of the strobe and stays busy for 20 cycles.
    bit resp_en = 1'b0;
    always begin
        @(negedge clk);
        if (resp_en && sel_if.COLOR_SEL_SIG === 1'b1) begin
            repeat (2) @(negedge clk);
            chg = 1'b1;
            repeat (20) @(negedge clk);
            chg = 1'b0;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn(input int which, input int hold);
        if (which == 0) btn_l = 1'b1; else if (which == 1) btn_r = 1'b1; else btn_c = 1'b1;
        tick(hold);
        btn_l = 1'b0; btn_r = 1'b0; btn_c = 1'b0;
        tick(10);
    endtask

    task automatic do_confirm(output bit seen, output int hi, output int selv);
        seen = 1'b0; hi = 0; selv = 0;
        btn_c = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (sel_if.COLOR_SEL_SIG === 1'b1) seen = 1'b1;
        end
        if (seen) begin
            selv = int'(sel_if.COLOR_SELECTED);
            while (sel_if.COLOR_SEL_SIG === 1'b1 && hi < 50) begin
                hi++;
                @(negedge clk);
            end
        end
        btn_c = 1'b0;
        tick(10);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit seen;
        int hi, selv, e0, c0;
        #1 rst_n = 1'b0;
        tick(3);
        check("reset cursor", int'(cursor), 0);
        check("reset sig", int'(sel_if.COLOR_SEL_SIG), 0);
        check("reset moves", int'(move_count), 0);
        check("reset req_error", int'(req_err), 0);
        rst_n = 1'b1;
        tick(3);

        c0 = cursor_moves;
        press_btn(0, 2);
        check("short pulse ignored", int'(cursor), 0);
        press_btn(0, 10);
        check("left wrap to N-1", int'(cursor), 5);
        check("model left wrap", m_cursor, 5);
        check("single move on hold", cursor_moves - c0, 1);

        press_btn(0, 10);
        press_btn(0, 10);
        check("cursor at 3", int'(cursor), 3);
        cur_color = 3'd1;
        resp_en = 1'b1;
        do_confirm(seen, hi, selv);
        check("request issued", int'(seen), 1);
        check("strobe length to ack", hi, 3);
        check("selected colour", selv, 3);
        tick(30);
        check("move counted", int'(move_count), 1);

        press_btn(0, 10);
        cur_color = 3'd2;
        do_confirm(seen, hi, selv);
        check("same colour dropped", int'(seen), 0);
        check("moves unchanged same colour", int'(move_count), 1);

        resp_en = 1'b0;
        cur_color = 3'd1;
        e0 = err_seen;
        do_confirm(seen, hi, selv);
        check("timeout request issued", int'(seen), 1);
        check("strobe length to timeout", hi, 8);
        check("single req_error pulse", err_seen - e0, 1);
        check("moves unchanged timeout", int'(move_count), 1);

        resp_en = 1'b1;
        do_confirm(seen, hi, selv);
        check("retry accepted", int'(seen), 1);
        tick(30);
        check("second move counted", int'(move_count), 2);
        check("out of moves", int'(oom), 1);
        do_confirm(seen, hi, selv);
        check("confirm at limit dropped", int'(seen), 0);
        check("model moves at limit", m_moves, 2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        check("new game moves", int'(move_count), 0);
        check("new game oom", int'(oom), 0);
        check("new game cursor", int'(cursor), 0);

        resp_en = 1'b0;
        btn_c = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (sel_if.COLOR_SEL_SIG === 1'b1) seen = 1'b1;
        end
        check("request before reset", int'(seen), 1);
        #2;
        rst_n = 1'b0;
        btn_c = 1'b0;
        #1;
        check("async reset drops sig", int'(sel_if.COLOR_SEL_SIG), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);

        color_num = 4'd6;
        press_btn(0, 10);
        check("cursor 5 before shrink", int'(cursor), 5);
        color_num = 4'd3;
        @(negedge clk);
        check("cursor forced to 0", int'(cursor), 0);

        color_num = 4'd12;
        press_btn(0, 10);
        check("clamped N=8 wrap", int'(cursor), 7);
        press_btn(1, 10);
        check("right wrap to 0", int'(cursor), 0);
        color_num = 4'd1;
        press_btn(0, 10);
        check("clamped N=2 wrap", int'(cursor), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/color_select_ctrl.md
Name: color_select_ctrl

Overview:
- Initiator side of the colour-selection handshake that the game-logic block responds to.
- Turns player buttons into a palette cursor, then issues one colour request per confirmed move: COLOR_SELECTED held stable with COLOR_SEL_SIG.
- Tracks the responder's CHANGING_COLOR busy flag, counts completed moves, and enforces a move limit.
- Sits between the button inputs and game logic. Its outputs also feed the display (cursor, move count).

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: a synchronised button level must be stable this many cycles before it is accepted.
- ACK_TIMEOUT, 16'd1000: maximum cycles in REQ waiting for CHANGING_COLOR=1.
- MOVE_LIMIT, 8'd25: maximum completed moves per game.

Ports:
- CLOCK, input, 1: system clock; all logic on posedge.
- RESET_N, input, 1: asynchronous, active-low reset.
- BTN_LEFT, input, 1: raw button, asynchronous to CLOCK.
- BTN_RIGHT, input, 1: raw button, asynchronous to CLOCK.
- BTN_CONFIRM, input, 1: raw button, asynchronous to CLOCK.
- COLOR_NUM, input, 4: number of colours in play.
- CURRENT_COLOR, input, 3: present colour of the flooded region (cell 0,0).
- START_NEW_GAME, input, 1: level; new-game request.
- CHANGING_COLOR, input, 1: responder busy flag.
- COLOR_SELECTED, output, 3: requested colour; stable while COLOR_SEL_SIG=1.
- COLOR_SEL_SIG, output, 1: request strobe/level.
- CURSOR, output, 3: palette cursor position.
- MOVE_COUNT, output, 8: completed moves this game.
- OUT_OF_MOVES, output, 1: high when MOVE_COUNT >= MOVE_LIMIT.
- REQ_ERROR, output, 1: one-cycle pulse on acknowledge timeout.

Behaviour:
- Reset values (RESET_N=0, async):
  - COLOR_SELECTED=0, COLOR_SEL_SIG=0, CURSOR=0, MOVE_COUNT=0, OUT_OF_MOVES=0, REQ_ERROR=0.
  - State IDLE; debounce counters 0; debounced levels 0.
- Buttons:
  - Each button passes through a 2-flop synchroniser, then a debounce counter. The counter resets on any change of the synchronised level and updates the debounced level when it reaches DEBOUNCE_CYCLES-1.
  - A press is the rising edge of the debounced level: a one-cycle internal pulse. Holding a button gives exactly one press.
- Effective colour count: N = 2 if COLOR_NUM<2, 8 if COLOR_NUM>8, else COLOR_NUM.
- Cursor:
  - LEFT press: CURSOR = (CURSOR==0) ? N-1 : CURSOR-1.
  - RIGHT press: CURSOR = (CURSOR==N-1) ? 0 : CURSOR+1.
  - LEFT and RIGHT pressed in the same cycle: no change.
  - If CURSOR >= N, for example after COLOR_NUM drops, CURSOR is forced to 0 on the next cycle; this has priority over presses.
  - The cursor moves in any state except while START_NEW_GAME=1.
- FSM states: IDLE, REQ, BUSY.
- IDLE:
  - A CONFIRM press is accepted only if CURSOR != CURRENT_COLOR, OUT_OF_MOVES=0 and CHANGING_COLOR=0. Otherwise it is silently dropped.
  - On accept: COLOR_SELECTED<=CURSOR, COLOR_SEL_SIG<=1, timeout counter<=0, go to REQ. COLOR_SEL_SIG rises on the cycle after the press pulse.
- REQ:
  - Hold COLOR_SEL_SIG=1 and COLOR_SELECTED unchanged; increment the timeout counter.
  - On CHANGING_COLOR=1: COLOR_SEL_SIG<=0, go to BUSY.
  - If the counter reaches ACK_TIMEOUT-1 without acknowledgement: COLOR_SEL_SIG<=0, REQ_ERROR=1 for one cycle, go to IDLE, no move counted.
- BUSY:
  - Wait for CHANGING_COLOR=0.
  - Then MOVE_COUNT<=MOVE_COUNT+1, saturating at 255, and go to IDLE.
  - CONFIRM presses in REQ or BUSY are dropped, not queued.
- OUT_OF_MOVES is registered: (next MOVE_COUNT >= MOVE_LIMIT). It updates in the same cycle as MOVE_COUNT.
- START_NEW_GAME=1, from any state, synchronous, highest priority after reset:
  - State<=IDLE, COLOR_SEL_SIG<=0, MOVE_COUNT<=0, OUT_OF_MOVES<=0, CURSOR<=0, timeout counter<=0.
  - An outstanding request is abandoned.
  - The controller stays inert until START_NEW_GAME returns to 0.
- Only one request is ever outstanding. COLOR_SEL_SIG never re-asserts until the previous CHANGING_COLOR has fallen.

Test Plan:
1. DEBOUNCE_CYCLES=4, COLOR_NUM=6, CURSOR=0. Pulse BTN_LEFT for 2 cycles -> no change. Hold it 10 cycles -> CURSOR=5 exactly once.
2. CURSOR=3, CURRENT_COLOR=1, confirm. Responder raises CHANGING_COLOR 3 cycles after SIG and drops it 20 cycles later -> COLOR_SEL_SIG high for 3 cycles with COLOR_SELECTED=3, cleared the cycle after the acknowledge, MOVE_COUNT 0->1 one cycle after CHANGING_COLOR falls.
3. CURSOR=2, CURRENT_COLOR=2, confirm -> COLOR_SEL_SIG stays 0 and MOVE_COUNT is unchanged.
4. ACK_TIMEOUT=8, responder never acknowledges -> SIG high for 8 cycles, then a single REQ_ERROR pulse, IDLE, MOVE_COUNT unchanged. A new confirm is then accepted.
5. MOVE_LIMIT=2, complete 2 moves -> OUT_OF_MOVES=1 and a third confirm is ignored. Then assert START_NEW_GAME for 1 cycle -> MOVE_COUNT=0, OUT_OF_MOVES=0, CURSOR=0.
6. Assert RESET_N=0 mid-REQ, asynchronously between clock edges -> COLOR_SEL_SIG drops immediately, before the next edge. Then COLOR_NUM=3 with CURSOR=5 -> CURSOR=0 next cycle.
